// File: rtl/matrix_operand_loader.sv
// Purpose: assembles an 18-beat serial element stream into parallel 3x3 operands A and B (column-major); optional SOF framing via MAT_LOAD_SOF_EN.
// Latency: mat_valid rises the cycle after the 18th accepted beat; at least 19 cycles per frame, no overlap between frames.
// Backpressure: in_ready drops while a full frame is held; the frame is released on mat_ready, and beats offered meanwhile must be held by the source.
module matrix_operand_loader #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic [DW-1:0] a3,
    output logic [DW-1:0] a4,
    output logic [DW-1:0] a5,
    output logic [DW-1:0] a6,
    output logic [DW-1:0] a7,
    output logic [DW-1:0] a8,
    output logic [DW-1:0] a9,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] b3,
    output logic [DW-1:0] b4,
    output logic [DW-1:0] b5,
    output logic [DW-1:0] b6,
    output logic [DW-1:0] b7,
    output logic [DW-1:0] b8,
    output logic [DW-1:0] b9,
    output logic          mat_valid,
    input  logic          mat_ready,
    output logic          frame_err
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic          wr_en;
    logic [4:0]    wr_idx;
    logic          err_d;
    logic          accept;
    logic [DW-1:0] elem_q [18];

`ifndef MAT_LOAD_SOF_EN
    // Start-of-frame marker has no meaning when framing is by beat count only.
    logic unused_sof;
    assign unused_sof = in_sof;
`endif

    assign in_ready = (state_q != FULL);
    assign accept   = in_valid & in_ready;

    // Next-state, beat index and element write decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        err_d   = 1'b0;
        case (state_q)
            FULL: begin
                if (mat_ready) state_d = LOAD_A;
            end
            default: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q == 5'd17) begin
                        idx_d   = 5'd0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd8) state_d = LOAD_B;
                    end
`ifdef MAT_LOAD_SOF_EN
                    // SOF always restarts the frame at a1; a beat without SOF
                    // at frame start is swallowed as a framing error.
                    if (in_sof) begin
                        wr_idx  = 5'd0;
                        idx_d   = 5'd1;
                        state_d = LOAD_A;
                        err_d   = (idx_q != 5'd0);
                    end else if (idx_q == 5'd0) begin
                        wr_en   = 1'b0;
                        idx_d   = 5'd0;
                        state_d = LOAD_A;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    // State, index, handshake and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD_A;
            idx_q     <= 5'd0;
            mat_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mat_valid <= (state_d == FULL);
            frame_err <= err_d;
        end
    end

    // Element storage: each slot changes only when its own beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 18; i++) elem_q[i] <= '0;
        end else if (wr_en) begin
            elem_q[wr_idx] <= in_data;
        end
    end

    assign a1 = elem_q[0];
    assign a2 = elem_q[1];
    assign a3 = elem_q[2];
    assign a4 = elem_q[3];
    assign a5 = elem_q[4];
    assign a6 = elem_q[5];
    assign a7 = elem_q[6];
    assign a8 = elem_q[7];
    assign a9 = elem_q[8];
    assign b1 = elem_q[9];
    assign b2 = elem_q[10];
    assign b3 = elem_q[11];
    assign b4 = elem_q[12];
    assign b5 = elem_q[13];
    assign b6 = elem_q[14];
    assign b7 = elem_q[15];
    assign b8 = elem_q[16];
    assign b9 = elem_q[17];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed frames plus random traffic against a frame-level model.
// Model tracks fill count, full flag and the 18 stored elements; compared every cycle on the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_matrix_operand_loader;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sof = 1'b0;
    logic [DW-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic [DW-1:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic          mat_valid;
    logic          mat_ready = 1'b0;
    logic          frame_err;

    matrix_operand_loader #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8), .b9(b9),
        .mat_valid(mat_valid), .mat_ready(mat_ready), .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;
    bit run = 1'b1;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: beats fill slots in arrival order; 18 beats make a frame.
    bit         m_full;
    int         m_cnt;
    logic [7:0] m_elem [18];
    bit         m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_cnt  = 0;
            m_err  = 1'b0;
            for (int i = 0; i < 18; i++) m_elem[i] = 8'd0;
        end else begin
            m_err = 1'b0;
            if (m_full) begin
                if (mat_ready) m_full = 1'b0;
            end else if (in_valid) begin
`ifdef MAT_LOAD_SOF_EN
                if (in_sof) begin
                    m_err     = (m_cnt != 0);
                    m_elem[0] = in_data;
                    m_cnt     = 1;
                end else if (m_cnt == 0) begin
                    m_err = 1'b1;
                end else begin
`else
                begin
`endif
                    m_elem[m_cnt] = in_data;
                    m_cnt++;
                    if (m_cnt == 18) begin
                        m_cnt  = 0;
                        m_full = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [143:0] dut_vec();
        return {a1, a2, a3, a4, a5, a6, a7, a8, a9, b1, b2, b3, b4, b5, b6, b7, b8, b9};
    endfunction

    function automatic logic [143:0] model_vec();
        logic [143:0] v = '0;
        for (int i = 0; i < 18; i++) v[143-8*i -: 8] = m_elem[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (run) begin
            check("in_ready", in_ready, !m_full);
            check("mat_valid", mat_valid, m_full);
            check("frame_err", frame_err, m_err);
            check("elements", dut_vec(), model_vec());
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic sof);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic release_frame();
        mat_ready = 1'b1;
        @(posedge clk); #1;
        mat_ready = 1'b0;
    endtask

    function automatic int c1_of();
        return int'(a1) * int'(b1) + int'(a4) * int'(b2) + int'(a7) * int'(b3);
    endfunction

    function automatic int c9_of();
        return int'(a3) * int'(b7) + int'(a6) * int'(b8) + int'(a9) * int'(b9);
    endfunction

    initial begin
        // 1: reset state
        #2;
        check("rst_mat_valid", mat_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_elements", dut_vec(), 144'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: back-to-back 1..18
        for (int i = 1; i <= 18; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_sof   = (i == 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("t2_mat_valid", mat_valid, 1'b1);
        check("t2_a1", a1, 8'd1);
        check("t2_a9", a9, 8'd9);
        check("t2_b1", b1, 8'd10);
        check("t2_b9", b9, 8'd18);
        check("t2_c1", c1_of(), 138);

        // 3: consumer stalls with a beat waiting
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("t3_in_ready_held", in_ready, 1'b0);
        check("t3_b9_held", b9, 8'd18);
        in_valid = 1'b0;
        release_frame();
        check("t3_mat_valid_fall", mat_valid, 1'b0);
        check("t3_in_ready_back", in_ready, 1'b1);

        // 4: in_valid toggling every cycle
        for (int i = 1; i <= 18; i++) begin
            send_beat(8'(i), i == 1);
            if (i < 18) begin
                @(posedge clk); #1;
            end
        end
        check("t4_mat_valid", mat_valid, 1'b1);
        check("t4_c1", c1_of(), 138);
        release_frame();

        // 5: reset mid-frame, then all-255 frame
        for (int i = 0; i < 12; i++) send_beat(8'($urandom_range(1, 255)), i == 0);
        rst_n = 1'b0;
        #2;
        check("t5_rst_elements", dut_vec(), 144'd0);
        check("t5_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) send_beat(8'd255, i == 0);
        check("t5_mat_valid", mat_valid, 1'b1);
        check("t5_c1", c1_of(), 195075);
        check("t5_c9", c9_of(), 195075);
        release_frame();

        // 6: SOF arriving on the 5th beat
        for (int i = 0; i < 4; i++) send_beat(8'(i + 1), i == 0);
        send_beat(8'h55, 1'b1);
`ifdef MAT_LOAD_SOF_EN
        check("t6_frame_err", frame_err, 1'b1);
        check("t6_a1", a1, 8'h55);
        for (int i = 0; i < 17; i++) send_beat(8'(i + 100), 1'b0);
`else
        check("t6_frame_err", frame_err, 1'b0);
        check("t6_a5", a5, 8'h55);
        for (int i = 0; i < 13; i++) send_beat(8'(i + 100), 1'b0);
`endif
        check("t6_mat_valid", mat_valid, 1'b1);
        release_frame();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_sof    = ($urandom_range(0, 9) == 0);
            mat_ready = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        mat_ready = 1'b0;
        @(posedge clk); #1;

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
